// File: rtl/if_stage_pkg.sv
// Shared control encodings for the fetch stage and the controller.
// Holds the next-PC select codes, the exception cause codes, the default vectors and the FSM state type.
package if_stage_pkg;

  localparam logic [2:0] NPC_PLUS4  = 3'd0;
  localparam logic [2:0] NPC_BRANCH = 3'd1;
  localparam logic [2:0] NPC_JUMP   = 3'd2;
  localparam logic [2:0] NPC_JR     = 3'd3;
  localparam logic [2:0] NPC_EXCEPT = 3'd4;

  localparam logic [1:0] CAUSE_NONE     = 2'd0;
  localparam logic [1:0] CAUSE_NPC      = 2'd1;
  localparam logic [1:0] CAUSE_MISALIGN = 2'd2;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'd3;

  localparam logic [31:0] RESET_PC_DEFAULT   = 32'h0000_3000;
  localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'h0000_4180;

  typedef enum logic {
    ST_FETCH = 1'b0,
    ST_EXEC  = 1'b1
  } if_state_e;

  function automatic logic word_misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/if_stage_npc_calc.sv
// Combinational next-PC target computation.
// EXCEPT and the unused encodings fall through to the sequential address; the caller decides on exceptions.
module npc_calc
  import if_stage_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [2:0]  npc_op,
  input  logic [15:0] imm16,
  input  logic [25:0] imm26,
  input  logic [31:0] rs_data,
  output logic [31:0] target,
  output logic        misaligned
);

  logic [31:0] seq_pc;
  logic [31:0] br_off;
  logic [31:0] br_target;
  logic [31:0] j_target;

  assign seq_pc    = pc + 32'd4;
  assign br_off    = {{14{imm16[15]}}, imm16, 2'b00};
  assign br_target = seq_pc + br_off;
  assign j_target  = {seq_pc[31:28], imm26, 2'b00};

  // Select the target and flag word-misaligned register/branch targets
  always_comb begin
    target     = seq_pc;
    misaligned = 1'b0;
    case (npc_op)
      NPC_BRANCH: begin
        target     = br_target;
        misaligned = word_misaligned(br_target);
      end
      NPC_JUMP: begin
        target     = j_target;
        misaligned = 1'b0;
      end
      NPC_JR: begin
        target     = rs_data;
        misaligned = word_misaligned(rs_data);
      end
      default: begin
        target     = seq_pc;
        misaligned = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: two-state FETCH/EXEC sequencer with PC, instruction latch,
// fetch-timeout counter and exception capture (epc/cause).
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEFAULT,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  npc_op,
  input  logic [15:0] imm16,
  input  logic [25:0] imm26,
  input  logic [31:0] rs_data,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] instr,
  output logic        nop,
  output logic [31:0] epc,
  output logic [1:0]  cause
);

  localparam int unsigned   CW     = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_VAL = CW'(TIMEOUT);

  if_state_e   state;
  logic [CW-1:0] tcnt;
  logic [31:0] target;
  logic        misaligned;
  logic        take_ack;
  logic        exc;
  logic [1:0]  exc_code;
  logic        retire;

  npc_calc u_npc_calc (
    .pc         (pc),
    .npc_op     (npc_op),
    .imm16      (imm16),
    .imm26      (imm26),
    .rs_data    (rs_data),
    .target     (target),
    .misaligned (misaligned)
  );

  assign imem_addr = pc;

  // Decide this cycle's event: accepted ack, exception (with code) or normal retire.
  // imem_req is low in the reset-release cycle, so an ack there is not accepted.
  always_comb begin
    take_ack = 1'b0;
    exc      = 1'b0;
    exc_code = CAUSE_NONE;
    retire   = 1'b0;
    case (state)
      ST_FETCH: begin
        if (!imem_req) begin
          take_ack = 1'b0;
        end else if (imem_ack) begin
          take_ack = 1'b1;
        end else if (tcnt == TO_VAL) begin
          exc      = 1'b1;
          exc_code = CAUSE_TIMEOUT;
        end else begin
          take_ack = 1'b0;
        end
      end
      ST_EXEC: begin
        if (stall) begin
          retire = 1'b0;
        end else if (npc_op == NPC_EXCEPT) begin
          exc      = 1'b1;
          exc_code = CAUSE_NPC;
        end else if (misaligned) begin
          exc      = 1'b1;
          exc_code = CAUSE_MISALIGN;
        end else begin
          retire = 1'b1;
        end
      end
      default: begin
        retire = 1'b0;
      end
    endcase
  end

  // Sequencer, PC/instruction registers, timeout counter and exception capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_FETCH;
      pc       <= RESET_PC;
      pc_plus4 <= RESET_PC + 32'd4;
      instr    <= 32'd0;
      epc      <= 32'd0;
      cause    <= CAUSE_NONE;
      tcnt     <= '0;
      imem_req <= 1'b0;
      nop      <= 1'b1;
    end else begin
      if (exc) begin
        pc       <= EXC_VECTOR;
        pc_plus4 <= EXC_VECTOR + 32'd4;
        epc      <= pc;
        cause    <= exc_code;
      end else if (retire) begin
        pc       <= target;
        pc_plus4 <= target + 32'd4;
      end
      case (state)
        ST_FETCH: begin
          if (take_ack) begin
            instr    <= imem_rdata;
            state    <= ST_EXEC;
            imem_req <= 1'b0;
            nop      <= 1'b0;
          end else if (exc) begin
            tcnt     <= '0;
            imem_req <= 1'b1;
          end else begin
            imem_req <= 1'b1;
            if (imem_req) begin
              tcnt <= tcnt + CW'(1);
            end
          end
        end
        ST_EXEC: begin
          if (!stall) begin
            state    <= ST_FETCH;
            tcnt     <= '0;
            imem_req <= 1'b1;
            nop      <= 1'b1;
          end
        end
        default: begin
          state    <= ST_FETCH;
          tcnt     <= '0;
          imem_req <= 1'b1;
          nop      <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Directed self-checking bench for if_stage with hand-computed expected values.
module tb_if_stage;

  localparam int unsigned TIMEOUT = 255;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  npc_op;
  logic [15:0] imm16;
  logic [25:0] imm26;
  logic [31:0] rs_data;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] instr;
  logic        nop;
  logic [31:0] epc;
  logic [1:0]  cause;

  int checks = 0;
  int errors = 0;

  if_stage #(
    .RESET_PC   (32'h0000_3000),
    .EXC_VECTOR (32'h0000_4180),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .npc_op     (npc_op),
    .imm16      (imm16),
    .imm26      (imm26),
    .rs_data    (rs_data),
    .stall      (stall),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .pc         (pc),
    .pc_plus4   (pc_plus4),
    .instr      (instr),
    .nop        (nop),
    .epc        (epc),
    .cause      (cause)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  // accept one fetch immediately (assumes FETCH with imem_req high)
  task automatic fetch(input logic [31:0] word);
    imem_ack   = 1'b1;
    imem_rdata = word;
    step(1);
    imem_ack   = 1'b0;
  endtask

  task automatic exec(input logic [2:0] op, input logic [15:0] i16, input logic [25:0] i26,
                      input logic [31:0] rs);
    npc_op  = op;
    imm16   = i16;
    imm26   = i26;
    rs_data = rs;
    step(1);
    npc_op  = 3'd0;
  endtask

  initial begin
    rst_n      = 1'b0;
    npc_op     = 3'd0;
    imm16      = 16'h0000;
    imm26      = 26'h0000000;
    rs_data    = 32'h0000_0000;
    stall      = 1'b0;
    imem_ack   = 1'b0;
    imem_rdata = 32'h0000_0000;

    #12;
    chk("rst_req",   {31'd0, imem_req}, 32'd0);
    chk("rst_pc",    pc, 32'h0000_3000);
    chk("rst_instr", instr, 32'h0000_0000);
    chk("rst_epc",   epc, 32'h0000_0000);
    chk("rst_cause", {30'd0, cause}, 32'd0);
    chk("rst_nop",   {31'd0, nop}, 32'd1);

    // reset release, ack on cycle 3
    @(negedge clk);
    rst_n = 1'b1;
    step(1);
    chk("rel_req",  {31'd0, imem_req}, 32'd1);
    chk("rel_addr", imem_addr, 32'h0000_3000);
    step(1);
    fetch(32'h2408_0005);
    chk("f1_instr", instr, 32'h2408_0005);
    chk("f1_nop",   {31'd0, nop}, 32'd0);
    chk("f1_req",   {31'd0, imem_req}, 32'd0);
    exec(3'd0, 16'h0000, 26'h0, 32'h0);
    chk("p4_nop",   {31'd0, nop}, 32'd1);
    chk("p4_pc",    pc, 32'h0000_3004);
    chk("p4_pcp4",  pc_plus4, 32'h0000_3008);

    // ack during a stalled EXEC is ignored
    fetch(32'h1111_2222);
    stall      = 1'b1;
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    step(1);
    imem_ack   = 1'b0;
    stall      = 1'b0;
    chk("exack_instr", instr, 32'h1111_2222);
    chk("exack_pc",    pc, 32'h0000_3004);
    exec(3'd2, 16'h0000, 26'h0000C04, 32'h0);
    chk("jmp_pc", pc, 32'h0000_3010);

    // branches
    fetch(32'h1000_FFFC);
    exec(3'd1, 16'hFFFC, 26'h0, 32'h0);
    chk("br_back", pc, 32'h0000_3004);
    fetch(32'h0800_0C04);
    exec(3'd2, 16'h0000, 26'h0000C04, 32'h0);
    fetch(32'h1000_0003);
    exec(3'd1, 16'h0003, 26'h0, 32'h0);
    chk("br_fwd", pc, 32'h0000_3020);

    // JR misaligned -> exception, then EXCEPT at the vector, then aligned JR
    fetch(32'h0800_0C00);
    exec(3'd2, 16'h0000, 26'h0000C00, 32'h0);
    chk("j3000_pc", pc, 32'h0000_3000);
    fetch(32'h0000_0008);
    exec(3'd3, 16'h0000, 26'h0, 32'h0000_3402);
    chk("jrmis_pc",    pc, 32'h0000_4180);
    chk("jrmis_epc",   epc, 32'h0000_3000);
    chk("jrmis_cause", {30'd0, cause}, 32'd2);
    fetch(32'h0000_000C);
    exec(3'd4, 16'h0000, 26'h0, 32'h0);
    chk("exc_pc",    pc, 32'h0000_4180);
    chk("exc_epc",   epc, 32'h0000_4180);
    chk("exc_cause", {30'd0, cause}, 32'd1);
    fetch(32'h0000_0008);
    exec(3'd3, 16'h0000, 26'h0, 32'h0000_3400);
    chk("jr_pc",       pc, 32'h0000_3400);
    chk("jr_epc_hold", epc, 32'h0000_4180);
    chk("jr_cause_hold", {30'd0, cause}, 32'd1);
    fetch(32'h0000_0000);
    exec(3'd5, 16'h0000, 26'h0, 32'h0);
    chk("op5_pc", pc, 32'h0000_3404);

    // stall for 4 EXEC cycles, then jump
    fetch(32'h0800_0C00);
    stall  = 1'b1;
    npc_op = 3'd2;
    imm26  = 26'h0000C00;
    for (int i = 0; i < 4; i++) begin
      step(1);
      chk("stall_pc",  pc, 32'h0000_3404);
      chk("stall_nop", {31'd0, nop}, 32'd0);
    end
    stall = 1'b0;
    step(1);
    npc_op = 3'd0;
    chk("stall_jmp_pc", pc, 32'h0000_3000);

    // fetch timeout at 0x3008
    fetch(32'h0000_0000);
    exec(3'd0, 16'h0000, 26'h0, 32'h0);
    fetch(32'h0000_0000);
    exec(3'd0, 16'h0000, 26'h0, 32'h0);
    chk("to_start_pc", pc, 32'h0000_3008);
    step(TIMEOUT);
    chk("to_edge_pc", pc, 32'h0000_3008);
    step(1);
    chk("to_pc",    pc, 32'h0000_4180);
    chk("to_epc",   epc, 32'h0000_3008);
    chk("to_cause", {30'd0, cause}, 32'd3);
    chk("to_req",   {31'd0, imem_req}, 32'd1);

    // ack in the cycle the counter reaches TIMEOUT wins
    step(TIMEOUT);
    fetch(32'hCAFE_0001);
    chk("toack_instr", instr, 32'hCAFE_0001);
    chk("toack_nop",   {31'd0, nop}, 32'd0);
    chk("toack_pc",    pc, 32'h0000_4180);
    chk("toack_cause", {30'd0, cause}, 32'd3);
    exec(3'd0, 16'h0000, 26'h0, 32'h0);
    chk("toack_next_pc", pc, 32'h0000_4184);

    // reset mid-FETCH with an ack in the release cycle
    step(1);
    rst_n = 1'b0;
    #1;
    chk("mrst_req", {31'd0, imem_req}, 32'd0);
    chk("mrst_pc",  pc, 32'h0000_3000);
    @(negedge clk);
    imem_ack   = 1'b1;
    imem_rdata = 32'h5555_AAAA;
    rst_n      = 1'b1;
    step(1);
    imem_ack   = 1'b0;
    chk("mrst_ack_instr", instr, 32'h0000_0000);
    chk("mrst_ack_nop",   {31'd0, nop}, 32'd1);
    chk("mrst_req_up",    {31'd0, imem_req}, 32'd1);
    fetch(32'h2408_0005);
    chk("mrst_refetch_instr", instr, 32'h2408_0005);
    chk("mrst_refetch_addr",  imem_addr, 32'h0000_3000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
